// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and baud divisor helper
// Contents: DATA_W (byte width shared with uart_rx), uart_state_e, clks_per_bit()
package uart_pkg;

    localparam int DATA_W = 8;

    // Codes 4-7 are unused; the transmitter treats them as IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } uart_state_e;

    // Integer-truncated divisor: every bit lasts exactly this many clocks,
    // with no fractional correction across a frame.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte write channel from a producer into the UART transmitter
// Signals: data_in, data_valid (producer -> transmitter)
//          fifo_full, overflow (transmitter -> producer)
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              fifo_full;
    logic              overflow;

    modport master (
        output data_in,
        output data_valid,
        input  fifo_full,
        input  overflow
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output fifo_full,
        output overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
// Ports: clk, rst_n (async active-low); push/push_data write side;
//        pop/pop_data read side (pop_data shows the head, valid while !empty);
//        full, empty, count status derived from the registered count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Requests against a full/empty FIFO are ignored here as a safety net.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with input byte FIFO
// Ports: clk, rst_n (async active-low); bus (uart_tx_if.slave: data_in,
//        data_valid in; fifo_full, overflow out); tx serial line (idle high);
//        busy (frame on the line or bytes queued); state (FSM code, debug)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       busy,
    output logic [2:0] state
);

    localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD);
    localparam int STOP_CLKS = STOP_BITS * CPB;
    localparam int CNT_W     = $clog2(STOP_CLKS + 1);
    localparam int FCNT_W    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [FCNT_W-1:0] fifo_count;

    // Push acceptance uses the registered full flag, so a strobe that lands
    // in the same cycle as a pop from a full FIFO is still dropped.
    assign fifo_push  = bus.data_valid && !fifo_full;
    assign overflow_d = bus.data_valid && fifo_full;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (bus.data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state and datapath. STOP pops straight into START when more bytes
    // are queued so back-to-back frames have no idle gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // Outputs are registered from the current state, so tx and busy trail the
    // FSM by one clock; busy therefore covers the whole frame on the wire.
    always_comb begin
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE) || (fifo_count != '0);
    end

    assign tx            = tx_q;
    assign busy          = busy_q;
    assign state         = state_q;
    assign bus.fifo_full = fifo_full;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed and random checks of uart_tx framing, FIFO, overflow and reset
module tb_uart_tx;

    localparam int FAST_CPB = 8;
    localparam int DEF_CPB  = 434;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_if if_f ();
    uart_tx_if if_d ();
    uart_tx_if if_s ();

    logic       tx_fast, busy_fast, tx_def, busy_def, tx_two, busy_two;
    logic [2:0] state_fast, state_def, state_two;

    uart_tx #(.CLK_FREQ(800), .BAUD(100), .FIFO_DEPTH(16), .STOP_BITS(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .bus(if_f), .tx(tx_fast), .busy(busy_fast), .state(state_fast)
    );
    uart_tx u_def (
        .clk(clk), .rst_n(rst_n), .bus(if_d), .tx(tx_def), .busy(busy_def), .state(state_def)
    );
    uart_tx #(.STOP_BITS(2)) u_two (
        .clk(clk), .rst_n(rst_n), .bus(if_s), .tx(tx_two), .busy(busy_two), .state(state_two)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [7:0] d);
        case (which)
            0: begin if_f.data_valid = v; if_f.data_in = d; end
            1: begin if_d.data_valid = v; if_d.data_in = d; end
            default: begin if_s.data_valid = v; if_s.data_in = d; end
        endcase
    endtask

    int         sel = 0;
    logic       mon_tx, mon_busy;
    logic [2:0] mon_state;
    always_comb begin
        case (sel)
            0: begin mon_tx = tx_fast; mon_busy = busy_fast; mon_state = state_fast; end
            1: begin mon_tx = tx_def;  mon_busy = busy_def;  mon_state = state_def;  end
            default: begin mon_tx = tx_two; mon_busy = busy_two; mon_state = state_two; end
        endcase
    end

    // Bench receiver on the fast instance: mid-bit sampling, LSB first.
    logic       rx_en = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;
    always begin
        @(negedge clk);
        if (rx_en && tx_fast === 1'b0) begin
            logic [7:0] rb;
            logic       st_bit, sp_bit;
            repeat (FAST_CPB / 2) @(negedge clk);
            st_bit = tx_fast;
            for (int i = 0; i < 8; i++) begin
                repeat (FAST_CPB) @(negedge clk);
                rb[i] = tx_fast;
            end
            repeat (FAST_CPB) @(negedge clk);
            sp_bit = tx_fast;
            if (st_bit !== 1'b0 || sp_bit !== 1'b1) rx_ferr++;
            rx_q.push_back(rb);
        end
    end

    int ovf_seen = 0;
    always @(negedge clk) begin
        if (if_f.overflow === 1'b1) ovf_seen <= ovf_seen + 1;
    end

    // Strobe one byte at the current negedge; k counts posedges after the
    // sampling edge. Expected line: frame bit (k-2)/cpb for k in [2, 2+total).
    task automatic check_frame(input string tag, input int which, input int cpb,
                               input int nstop, input logic [7:0] b);
        logic [10:0] frame;
        int total, bad, fall, bdrop, st_enter, st_last, st_idle;
        frame = {2'b11, b, 1'b0};
        total = (9 + nstop) * cpb;
        bad = 0; fall = -1; bdrop = -1; st_enter = -1; st_last = -1; st_idle = -1;
        sel = which;
        drive(which, 1'b1, b);
        @(negedge clk);
        drive(which, 1'b0, 8'h00);
        for (int k = 1; k <= total + 3; k++) begin
            logic exp_tx;
            @(negedge clk);
            if (k < 2 || k >= total + 2) exp_tx = 1'b1;
            else exp_tx = frame[(k - 2) / cpb];
            if (mon_tx !== exp_tx) bad++;
            if (fall < 0 && mon_tx === 1'b0) fall = k;
            if (bdrop < 0 && mon_busy === 1'b0) bdrop = k;
            if (k == 1 + 9 * cpb) st_enter = int'(mon_state);
            if (k == total) st_last = int'(mon_state);
            if (k == total + 1) st_idle = int'(mon_state);
        end
        check_eq({tag, "_bit_errors"}, bad, 0);
        check_eq({tag, "_fall_cycle"}, fall, 2);
        check_eq({tag, "_busy_drop"}, bdrop, total + 2);
        check_eq({tag, "_stop_enter"}, st_enter, 3);
        check_eq({tag, "_stop_last"}, st_last, 3);
        check_eq({tag, "_idle_after"}, st_idle, 0);
    endtask

    logic [7:0] exp_q[$];
    int         early, bdrop, t81, t82, exp_ovf, ovf_base, bad;

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check_eq("rst_tx", int'(tx_fast), 1);
        check_eq("rst_busy", int'(busy_fast), 0);
        check_eq("rst_full", int'(if_f.fifo_full), 0);
        check_eq("rst_overflow", int'(if_f.overflow), 0);
        check_eq("rst_state", int'(state_fast), 0);
        check_eq("rst_tx_def", int'(tx_def), 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte at default baud, then two stop bits
        check_frame("a5", 1, DEF_CPB, 1, 8'hA5);
        check_frame("81_2stop", 2, DEF_CPB, 2, 8'h81);

        // 0x00 then 0xFF back-to-back: no idle gap between frames
        sel = 0;
        rx_q.delete();
        rx_en = 1'b1;
        bdrop = -1; t81 = -1; t82 = -1;
        drive(0, 1'b1, 8'h00);
        @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        for (int k = 2; k <= 170; k++) begin
            @(negedge clk);
            if (k == 81) t81 = int'(tx_fast);
            if (k == 82) t82 = int'(tx_fast);
            if (bdrop < 0 && busy_fast === 1'b0) bdrop = k;
        end
        check_eq("b2b_stop_end", t81, 1);
        check_eq("b2b_next_start", t82, 0);
        check_eq("b2b_busy_drop", bdrop, 162);
        check_eq("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check_eq("b2b_rx0", int'(rx_q[0]), 8'h00);
            check_eq("b2b_rx1", int'(rx_q[1]), 8'hFF);
        end

        // 17 back-to-back strobes plus an 18th that overflows
        rx_q.delete();
        early = 0;
        for (int i = 0; i < 18; i++) begin
            drive(0, 1'b1, 8'(i + 1));
            @(negedge clk);
            if (i == 15) check_eq("full_after_16_pushes", int'(if_f.fifo_full), 0);
            if (i == 16) check_eq("full_after_17_pushes", int'(if_f.fifo_full), 1);
            if (i < 17 && if_f.overflow === 1'b1) early++;
            if (i == 17) check_eq("ovf_pulse", int'(if_f.overflow), 1);
        end
        drive(0, 1'b0, 8'h00);
        @(negedge clk);
        check_eq("ovf_one_cycle", int'(if_f.overflow), 0);
        check_eq("ovf_early", early, 0);
        for (int w = 0; w < 2000 && (rx_q.size() < 17 || busy_fast); w++) @(negedge clk);
        check_eq("burst_rx_count", rx_q.size(), 17);
        if (rx_q.size() == 17) begin
            for (int i = 0; i < 17; i++) check_eq($sformatf("burst_rx%0d", i), int'(rx_q[i]), i + 1);
        end

        // Reset during DATA bit 3 of 0x3C with two more bytes queued
        rx_en = 1'b0;
        drive(0, 1'b1, 8'h3C);
        @(negedge clk);
        drive(0, 1'b1, 8'h11);
        @(negedge clk);
        drive(0, 1'b1, 8'h22);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (34) @(negedge clk);
        check_eq("pre_rst_state", int'(state_fast), 2);
        check_eq("pre_rst_busy", int'(busy_fast), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", int'(tx_fast), 1);
        check_eq("mid_rst_state", int'(state_fast), 0);
        check_eq("mid_rst_busy", int'(busy_fast), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("post_rst_flushed_busy", int'(busy_fast), 0);
        check_eq("post_rst_tx", int'(tx_fast), 1);
        check_frame("55_after_rst", 0, FAST_CPB, 1, 8'h55);

        // Random stream with random gaps; drops decided by fifo_full at strobe
        rx_q.delete();
        exp_q.delete();
        rx_en = 1'b1;
        exp_ovf = 0;
        ovf_base = ovf_seen;
        for (int n = 0; n < 200; n++) begin
            int gap;
            logic [7:0] rb;
            gap = ($urandom_range(0, 99) < 60) ? 0 : int'($urandom_range(1, 300));
            repeat (gap) @(negedge clk);
            rb = 8'($urandom);
            if (if_f.fifo_full === 1'b1) exp_ovf++;
            else exp_q.push_back(rb);
            drive(0, 1'b1, rb);
            @(negedge clk);
            drive(0, 1'b0, 8'h00);
        end
        for (int w = 0; w < 5000 && (rx_q.size() < exp_q.size() || busy_fast); w++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_eq("rand_rx_count", rx_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) bad++;
        end
        check_eq("rand_rx_data_errors", bad, 0);
        check_eq("rand_overflow_count", ovf_seen - ovf_base, exp_ovf);
        check_eq("rx_framing_errors", rx_ferr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
